countdown_sequencer: RTL and testbench

- Controller for the watch's MM:SS countdown timer. It sequences set, run, pause and alarm.
- It owns the four BCD time digits and turns debounced button levels and the 1 Hz strobe into load, increment and decrement operations.
- It drives the buzzer and the 4-digit display bus, which feeds the display mux alongside the clock and stopwatch modes.

---
 rtl/countdown_pkg.sv | 32 +++
 rtl/bcd_mmss_counter.sv | 69 ++++++
 rtl/countdown_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_countdown_sequencer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/countdown_pkg.sv
// Shared types and constants for the MM:SS countdown timer.
// Included by countdown_sequencer and bcd_mmss_counter.
package countdown_pkg;

  typedef logic [3:0] bcd_t;

  typedef enum logic [1:0] {
    ST_SET   = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_ALARM = 2'd3
  } cd_state_t;

  localparam bcd_t SEC_TENS_MAX = 4'd5;
  localparam bcd_t MIN_TENS_MAX = 4'd5;
  localparam bcd_t BCD_ONES_MAX = 4'd9;

  // Increment a two-digit BCD field, wrapping tens_max:9 back to 0:0 with no carry out.
  function automatic logic [7:0] bcd_pair_inc(input bcd_t tens, input bcd_t ones,
                                              input bcd_t tens_max);
    logic [7:0] res;
    if (ones == BCD_ONES_MAX) begin
      res[3:0] = 4'd0;
      res[7:4] = (tens == tens_max) ? 4'd0 : tens + 4'd1;
    end else begin
      res[3:0] = ones + 4'd1;
      res[7:4] = tens;
    end
    return res;
  endfunction

endpackage

// File: rtl/bcd_mmss_counter.sv
// Four BCD digit registers for MM:SS with clear, load, per-field increment
// and whole-value decrement that saturates at 00:00.
module bcd_mmss_counter
  import countdown_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clr,
  input  logic        i_load,
  input  logic [15:0] i_load_val,
  input  logic        i_inc_sec,
  input  logic        i_inc_min,
  input  logic        i_dec,
  output bcd_t        o_num0,
  output bcd_t        o_num1,
  output bcd_t        o_num2,
  output bcd_t        o_num3,
  output logic        o_zero
);

  bcd_t r_num0;
  bcd_t r_num1;
  bcd_t r_num2;
  bcd_t r_num3;
  logic w_zero;

  assign w_zero = ({r_num3, r_num2, r_num1, r_num0} == 16'h0000);

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_num0 <= 4'd0;
      r_num1 <= 4'd0;
      r_num2 <= 4'd0;
      r_num3 <= 4'd0;
    end else if (i_load) begin
      {r_num3, r_num2, r_num1, r_num0} <= i_load_val;
    end else if (i_dec) begin
      // Borrow ripples ones -> tens -> minutes; at 00:00 the value holds.
      if (!w_zero) begin
        if (r_num0 != 4'd0) begin
          r_num0 <= r_num0 - 4'd1;
        end else begin
          r_num0 <= BCD_ONES_MAX;
          if (r_num1 != 4'd0) begin
            r_num1 <= r_num1 - 4'd1;
          end else begin
            r_num1 <= SEC_TENS_MAX;
            if (r_num2 != 4'd0) begin
              r_num2 <= r_num2 - 4'd1;
            end else begin
              r_num2 <= BCD_ONES_MAX;
              r_num3 <= r_num3 - 4'd1;
            end
          end
        end
      end
    end else begin
      if (i_inc_sec) {r_num1, r_num0} <= bcd_pair_inc(r_num1, r_num0, SEC_TENS_MAX);
      if (i_inc_min) {r_num3, r_num2} <= bcd_pair_inc(r_num3, r_num2, MIN_TENS_MAX);
    end
  end

  assign o_num0 = r_num0;
  assign o_num1 = r_num1;
  assign o_num2 = r_num2;
  assign o_num3 = r_num3;
  assign o_zero = w_zero;

endmodule

// File: rtl/countdown_sequencer.sv
// MM:SS countdown controller: button edge detect, SET/RUN/PAUSE/ALARM FSM, alarm timer.
// Define COUNTDOWN_PRESET_RELOAD_EN to restore the last started value on ALARM exit.
module countdown_sequencer
  import countdown_pkg::*;
#(
  parameter int ALARM_SECS = 10,
  parameter int TICK_W     = 8
) (
  input  logic       uclock,
  input  logic       reset,
  input  logic       tick,
  input  logic       mode_en,
  input  logic       btn_start,
  input  logic       btn_min,
  input  logic       btn_sec,
  input  logic       btn_clear,
  output bcd_t       num0,
  output bcd_t       num1,
  output bcd_t       num2,
  output bcd_t       num3,
  output logic       buzzer,
  output logic       running,
  output logic [1:0] state
);

  localparam logic [TICK_W-1:0] ALARM_LAST = TICK_W'(ALARM_SECS - 1);

  logic              r_btn_start;
  logic              r_btn_min;
  logic              r_btn_sec;
  logic              r_btn_clear;
  cd_state_t         r_state;
  logic              r_buzzer;
  logic              r_running;
  logic [TICK_W-1:0] r_alarm_cnt;

  logic        w_p_start;
  logic        w_p_min;
  logic        w_p_sec;
  logic        w_p_clear;
  cd_state_t   w_next_state;
  logic        w_clr;
  logic        w_dec;
  logic        w_inc_sec;
  logic        w_inc_min;
  logic        w_latch;
  logic        w_alarm_exit;
  logic        w_cnt_inc;
  logic        w_load;
  logic [15:0] w_load_val;
  logic        w_zero;
  logic        w_is_one;

  assign w_p_start = btn_start & ~r_btn_start;
  assign w_p_min   = btn_min   & ~r_btn_min;
  assign w_p_sec   = btn_sec   & ~r_btn_sec;
  assign w_p_clear = btn_clear & ~r_btn_clear;

  assign w_is_one = ({num3, num2, num1, num0} == 16'h0001);

  // Only events that actually take effect in the current state block lower ones.
  always_comb begin
    w_next_state = r_state;
    w_clr        = 1'b0;
    w_dec        = 1'b0;
    w_inc_sec    = 1'b0;
    w_inc_min    = 1'b0;
    w_latch      = 1'b0;
    w_alarm_exit = 1'b0;
    w_cnt_inc    = 1'b0;
    if (w_p_clear) begin
      w_next_state = ST_SET;
      w_clr        = 1'b1;
    end else if (!mode_en) begin
      if (r_state == ST_RUN) begin
        w_next_state = ST_PAUSE;
      end else if (r_state == ST_ALARM) begin
        w_next_state = ST_SET;
        w_alarm_exit = 1'b1;
      end
    end else begin
      case (r_state)
        ST_SET: begin
          if (w_p_start && !w_zero) begin
            w_next_state = ST_RUN;
            w_latch      = 1'b1;
          end else begin
            w_inc_sec = w_p_sec;
            w_inc_min = w_p_min;
          end
        end
        ST_RUN: begin
          if (w_p_start) begin
            w_next_state = ST_PAUSE;
          end else if (tick) begin
            w_dec = 1'b1;
            if (w_is_one) w_next_state = ST_ALARM;
          end
        end
        ST_PAUSE: begin
          if (w_p_start) w_next_state = ST_RUN;
        end
        ST_ALARM: begin
          if (w_p_start || (tick && (r_alarm_cnt == ALARM_LAST))) begin
            w_next_state = ST_SET;
            w_alarm_exit = 1'b1;
          end else if (tick) begin
            w_cnt_inc = 1'b1;
          end
        end
        default: w_next_state = ST_SET;
      endcase
    end
  end

  always_ff @(posedge uclock) begin
    if (reset) begin
      r_btn_start <= 1'b0;
      r_btn_min   <= 1'b0;
      r_btn_sec   <= 1'b0;
      r_btn_clear <= 1'b0;
      r_state     <= ST_SET;
      r_buzzer    <= 1'b0;
      r_running   <= 1'b0;
      r_alarm_cnt <= '0;
    end else begin
      r_btn_start <= btn_start;
      r_btn_min   <= btn_min;
      r_btn_sec   <= btn_sec;
      r_btn_clear <= btn_clear;
      r_state     <= w_next_state;
      r_buzzer    <= (w_next_state == ST_ALARM);
      r_running   <= (w_next_state == ST_RUN);
      if (w_next_state != ST_ALARM) begin
        r_alarm_cnt <= '0;
      end else if (w_cnt_inc) begin
        r_alarm_cnt <= r_alarm_cnt + 1'b1;
      end
    end
  end

`ifdef COUNTDOWN_PRESET_RELOAD_EN
  logic [15:0] r_preset;

  always_ff @(posedge uclock) begin
    if (reset || w_clr) begin
      r_preset <= '0;
    end else if (w_latch) begin
      r_preset <= {num3, num2, num1, num0};
    end
  end

  assign w_load     = w_alarm_exit;
  assign w_load_val = r_preset;
`else
  // Digits already read 00:00 in ALARM, so exit needs no load.
  logic w_unused_latch;
  assign w_unused_latch = w_latch;
  assign w_load         = 1'b0;
  assign w_load_val     = '0;
`endif

  bcd_mmss_counter u_digits (
    .i_clk      (uclock),
    .i_rst      (reset),
    .i_clr      (w_clr),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_inc_sec  (w_inc_sec),
    .i_inc_min  (w_inc_min),
    .i_dec      (w_dec),
    .o_num0     (num0),
    .o_num1     (num1),
    .o_num2     (num2),
    .o_num3     (num3),
    .o_zero     (w_zero)
  );

  assign buzzer  = r_buzzer;
  assign running = r_running;
  assign state   = r_state;

endmodule

// File: tb/tb_countdown_sequencer.sv
// Bench for countdown_sequencer: directed scenarios plus random stimulus,
// checked every cycle against a minutes/seconds integer model.
module tb_countdown_sequencer;

  localparam int ALARM_SECS = 10;

  logic       uclock = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       mode_en = 1'b1;
  logic       btn_start = 1'b0;
  logic       btn_min = 1'b0;
  logic       btn_sec = 1'b0;
  logic       btn_clear = 1'b0;
  logic [3:0] num0, num1, num2, num3;
  logic       buzzer, running;
  logic [1:0] state;

  int n_checks = 0;
  int n_fail = 0;

  always #5 uclock = ~uclock;

  countdown_sequencer #(.ALARM_SECS(ALARM_SECS), .TICK_W(8)) dut (
    .uclock    (uclock),
    .reset     (reset),
    .tick      (tick),
    .mode_en   (mode_en),
    .btn_start (btn_start),
    .btn_min   (btn_min),
    .btn_sec   (btn_sec),
    .btn_clear (btn_clear),
    .num0      (num0),
    .num1      (num1),
    .num2      (num2),
    .num3      (num3),
    .buzzer    (buzzer),
    .running   (running),
    .state     (state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] disp();
    return {16'h0, num3, num2, num1, num0};
  endfunction

  function automatic logic [31:0] exp_disp(input int mm, input int ss);
    return 32'((mm / 10) * 4096 + (mm % 10) * 256 + (ss / 10) * 16 + (ss % 10));
  endfunction

  // Model: 0=SET 1=RUN 2=PAUSE 3=ALARM; time held as integer minutes/seconds.
  int m_st = 0, m_mm = 0, m_ss = 0, m_cnt = 0, m_pre = 0;
  bit m_valid = 0;
  logic m_ps = 0, m_pm = 0, m_pse = 0, m_pc = 0;

  task automatic model_exit_alarm();
    m_st  = 0;
    m_cnt = 0;
`ifdef COUNTDOWN_PRESET_RELOAD_EN
    m_mm = m_pre / 60;
    m_ss = m_pre % 60;
`endif
  endtask

  always @(posedge uclock) begin
    logic ps, pm, pse, pc;
    int t;
    ps = btn_start && !m_ps;
    pm = btn_min && !m_pm;
    pse = btn_sec && !m_pse;
    pc = btn_clear && !m_pc;
    m_ps = btn_start; m_pm = btn_min; m_pse = btn_sec; m_pc = btn_clear;
    if (reset) begin
      m_st = 0; m_mm = 0; m_ss = 0; m_cnt = 0; m_pre = 0;
      m_ps = 0; m_pm = 0; m_pse = 0; m_pc = 0;
      m_valid = 1;
    end else if (m_valid) begin
      if (pc) begin
        m_st = 0; m_mm = 0; m_ss = 0; m_pre = 0; m_cnt = 0;
      end else if (!mode_en) begin
        if (m_st == 1) m_st = 2;
        else if (m_st == 3) model_exit_alarm();
      end else if (m_st == 0) begin
        if (ps && (m_mm * 60 + m_ss) != 0) begin
          m_pre = m_mm * 60 + m_ss;
          m_st = 1;
        end else begin
          if (pse) m_ss = (m_ss + 1) % 60;
          if (pm) m_mm = (m_mm + 1) % 60;
        end
      end else if (m_st == 1) begin
        if (ps) m_st = 2;
        else if (tick) begin
          t = m_mm * 60 + m_ss - 1;
          m_mm = t / 60;
          m_ss = t % 60;
          if (t == 0) m_st = 3;
        end
      end else if (m_st == 2) begin
        if (ps) m_st = 1;
      end else begin
        if (ps) model_exit_alarm();
        else if (tick) begin
          m_cnt++;
          if (m_cnt == ALARM_SECS) model_exit_alarm();
        end
      end
    end
    #1;
    if (m_valid) begin
      check("model_state", 32'(state), 32'(m_st));
      check("model_digits", disp(), exp_disp(m_mm, m_ss));
      check("model_buzzer", 32'(buzzer), 32'(m_st == 3));
      check("model_running", 32'(running), 32'(m_st == 1));
    end
  end

  // One-cycle pulse on the selected inputs, then one idle cycle.
  task automatic step(input logic st, input logic mi, input logic se,
                      input logic cl, input logic tk);
    @(negedge uclock);
    btn_start = st; btn_min = mi; btn_sec = se; btn_clear = cl; tick = tk;
    @(negedge uclock);
    btn_start = 0; btn_min = 0; btn_sec = 0; btn_clear = 0; tick = 0;
  endtask

  task automatic press_sec(input int n);
    repeat (n) step(0, 0, 1, 0, 0);
  endtask

  task automatic press_min(input int n);
    repeat (n) step(0, 1, 0, 0, 0);
  endtask

  task automatic ticks(input int n);
    repeat (n) step(0, 0, 0, 0, 1);
  endtask

  initial begin
    repeat (3) @(negedge uclock);
    reset = 0;
    check("reset_state", 32'(state), 0);
    check("reset_digits", disp(), 0);
    check("reset_buzzer", 32'(buzzer), 0);
    check("reset_running", 32'(running), 0);

    press_sec(3);
    press_min(2);
    step(1, 0, 0, 0, 0);
    check("set_0203", disp(), 32'h0203);
    check("start_run", 32'(state), 1);
    check("start_running", 32'(running), 1);

    ticks(122);
    check("run_0001", disp(), 32'h0001);
    ticks(1);
    check("alarm_digits", disp(), 0);
    check("alarm_state", 32'(state), 3);
    check("alarm_buzzer", 32'(buzzer), 1);
    ticks(ALARM_SECS - 1);
    check("alarm_hold", 32'(state), 3);
    ticks(1);
    check("alarm_timeout_state", 32'(state), 0);
    check("alarm_timeout_buzzer", 32'(buzzer), 0);

    step(0, 0, 0, 1, 0);
    press_min(1);
    step(1, 0, 0, 0, 0);
    ticks(1);
    check("borrow_0059", disp(), 32'h0059);
    step(1, 0, 0, 0, 1);
    check("pause_tick_drop_state", 32'(state), 2);
    check("pause_tick_drop_digits", disp(), 32'h0059);
    step(1, 0, 0, 0, 0);
    check("resume_run", 32'(state), 1);

    step(0, 0, 0, 1, 0);
    press_sec(59);
    check("set_0059", disp(), 32'h0059);
    press_sec(1);
    check("sec_wrap", disp(), 0);
    press_min(59);
    check("set_5900", disp(), 32'h5900);
    press_min(1);
    check("min_wrap", disp(), 0);
    step(1, 0, 0, 0, 0);
    check("start_zero_ignored", 32'(state), 0);

    press_sec(5);
    step(1, 0, 0, 0, 0);
    ticks(1);
    @(negedge uclock);
    mode_en = 0;
    @(negedge uclock);
    check("mode_low_pause", 32'(state), 2);
    step(1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 1);
    check("mode_low_frozen", disp(), 32'h0004);
    check("mode_low_state", 32'(state), 2);
    @(negedge uclock);
    mode_en = 1;
    step(0, 0, 0, 0, 0);
    check("no_auto_resume", 32'(state), 2);
    step(1, 0, 0, 0, 0);
    ticks(4);
    check("alarm2_state", 32'(state), 3);
    @(negedge uclock);
    reset = 1;
    @(negedge uclock);
    reset = 0;
    check("mid_alarm_reset_state", 32'(state), 0);
    check("mid_alarm_reset_buzzer", 32'(buzzer), 0);
    check("mid_alarm_reset_digits", disp(), 0);

`ifdef COUNTDOWN_PRESET_RELOAD_EN
    press_sec(5);
    step(1, 0, 0, 0, 0);
    ticks(5);
    check("preset_alarm", 32'(state), 3);
    step(1, 0, 0, 0, 0);
    check("preset_reload", disp(), 32'h0005);
    check("preset_state", 32'(state), 0);
`endif

    for (int i = 0; i < 6000; i++) begin
      @(negedge uclock);
      reset     = ($urandom_range(0, 799) == 0);
      btn_clear = ($urandom_range(0, 99) == 0);
      mode_en   = ($urandom_range(0, 29) != 0);
      btn_start = ($urandom_range(0, 11) == 0);
      btn_min   = ($urandom_range(0, 5) == 0);
      btn_sec   = ($urandom_range(0, 3) == 0);
      tick      = ($urandom_range(0, 2) == 0);
    end
    @(negedge uclock);
    reset = 0; btn_clear = 0; mode_en = 1; btn_start = 0;
    btn_min = 0; btn_sec = 0; tick = 0;
    repeat (4) @(negedge uclock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
